// File: rtl/cc_frogger_pkg.sv
// Shared encodings for the Frogger round controller: FSM states,
// comparator verdict codes and the decoded round event.
package cc_frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_PLAY = 3'b010,
    ST_HIT  = 3'b011,
    ST_WIN  = 3'b100,
    ST_OVER = 3'b101
  } state_e;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_MISS = 2'b01;
  localparam logic [1:0] CMP_WIN  = 2'b11;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_MISS = 2'b01,
    EV_WIN  = 2'b10
  } event_e;

  // Code 10 is reserved and deliberately folds into "no event".
  function automatic event_e decode_cmp(input logic [1:0] code);
    event_e ev;
    case (code)
      CMP_WIN:  ev = EV_WIN;
      CMP_MISS: ev = EV_MISS;
      CMP_NONE: ev = EV_NONE;
      default:  ev = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/cc_frogger_round_controller_holdcounter.sv
// Tick counter used to time the HIT/WIN dwell: synchronous clear,
// increment on qualified tick, done on the tick that completes the dwell.
module cc_tick_holdcounter #(
  parameter int HOLD_TICKS = 4,
  parameter int HOLD_WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_In,
  input  logic tick_In,
  output logic done_Out
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_TICKS - 1);

  logic [HOLD_WIDTH-1:0] count_q;
  logic [HOLD_WIDTH-1:0] count_d;

  // Clear has priority so the entry edge always restarts the dwell.
  always_comb begin
    count_d = count_q;
    if (clr_In) begin
      count_d = {HOLD_WIDTH{1'b0}};
    end else if (tick_In) begin
      count_d = count_q + HOLD_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {HOLD_WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done_Out = tick_In && (count_q == HOLD_LAST);

endmodule

// File: rtl/cc_frogger_round_controller.sv
// Frogger round sequencer: samples the lane comparator on game ticks,
// drives lane load/shift enables and keeps the lives and level counters.
module cc_frogger_round_controller
  import cc_frogger_pkg::*;
#(
  parameter int LIVES_WIDTH = 2,
  parameter int LIVES_INIT  = 3,
  parameter int LEVEL_WIDTH = 3,
  parameter int LEVEL_MAX   = 7,
  parameter int HOLD_TICKS  = 4,
  parameter int HOLD_WIDTH  = 3
) (
  input  logic                   CC_ROUNDCTRL_CLOCK_50,
  input  logic                   CC_ROUNDCTRL_RESET_InHigh,
  input  logic                   CC_ROUNDCTRL_tick_In,
  input  logic                   CC_ROUNDCTRL_start_In,
  input  logic [1:0]             CC_ROUNDCTRL_compare_InBUS,
  output logic                   CC_ROUNDCTRL_load_Out,
  output logic                   CC_ROUNDCTRL_shiftEnable_Out,
  output logic [2:0]             CC_ROUNDCTRL_state_OutBUS,
  output logic [LIVES_WIDTH-1:0] CC_ROUNDCTRL_lives_OutBUS,
  output logic [LEVEL_WIDTH-1:0] CC_ROUNDCTRL_level_OutBUS,
  output logic                   CC_ROUNDCTRL_gameOver_Out,
  output logic                   CC_ROUNDCTRL_gameWon_Out
);

  localparam logic [LIVES_WIDTH-1:0] LIVES_START = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST  = LEVEL_WIDTH'(LEVEL_MAX);

  logic clk;
  logic rst;
  assign clk = CC_ROUNDCTRL_CLOCK_50;
  assign rst = CC_ROUNDCTRL_RESET_InHigh;

  state_e                 state_q, state_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   won_q, won_d;
  logic                   load_q, load_d;
  logic                   shift_q, shift_d;
  logic                   over_q, over_d;
  logic                   hold_clr_s;
  logic                   hold_tick_s;
  logic                   hold_done_s;
  event_e                 event_s;

  assign event_s     = decode_cmp(CC_ROUNDCTRL_compare_InBUS);
  assign hold_tick_s = CC_ROUNDCTRL_tick_In && ((state_q == ST_HIT) || (state_q == ST_WIN));

  cc_tick_holdcounter #(
    .HOLD_TICKS (HOLD_TICKS),
    .HOLD_WIDTH (HOLD_WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clr_In   (hold_clr_s),
    .tick_In  (hold_tick_s),
    .done_Out (hold_done_s)
  );

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lives_q <= LIVES_START;
      level_q <= {LEVEL_WIDTH{1'b0}};
      won_q   <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      won_q   <= won_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      over_q  <= over_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    won_d      = won_q;
    hold_clr_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (CC_ROUNDCTRL_start_In) begin
          lives_d = LIVES_START;
          level_d = {LEVEL_WIDTH{1'b0}};
          won_d   = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (CC_ROUNDCTRL_tick_In) begin
          case (event_s)
            EV_WIN: begin
              state_d    = ST_WIN;
              hold_clr_s = 1'b1;
              if (level_q < LEVEL_LAST) begin
                level_d = level_q + LEVEL_WIDTH'(1);
              end else begin
                won_d = 1'b1;
              end
            end
            EV_MISS: begin
              state_d    = ST_HIT;
              hold_clr_s = 1'b1;
              // Lives are >= 1 whenever PLAY is reached; guard anyway.
              if (lives_q != {LIVES_WIDTH{1'b0}}) begin
                lives_d = lives_q - LIVES_WIDTH'(1);
              end else begin
                lives_d = lives_q;
              end
            end
            default: begin
              state_d = ST_PLAY;
            end
          endcase
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_HIT: begin
        if (hold_done_s) begin
          state_d = (lives_q == {LIVES_WIDTH{1'b0}}) ? ST_OVER : ST_LOAD;
        end else begin
          state_d = ST_HIT;
        end
      end
      ST_WIN: begin
        if (hold_done_s) begin
          state_d = won_q ? ST_OVER : ST_LOAD;
        end else begin
          state_d = ST_WIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    load_d  = 1'b0;
    shift_d = 1'b0;
    over_d  = 1'b0;
    case (state_d)
      ST_LOAD: load_d  = 1'b1;
      ST_PLAY: shift_d = 1'b1;
      ST_OVER: over_d  = 1'b1;
      default: begin
        load_d  = 1'b0;
        shift_d = 1'b0;
        over_d  = 1'b0;
      end
    endcase
  end

  assign CC_ROUNDCTRL_load_Out        = load_q;
  assign CC_ROUNDCTRL_shiftEnable_Out = shift_q;
  assign CC_ROUNDCTRL_state_OutBUS    = state_q;
  assign CC_ROUNDCTRL_lives_OutBUS    = lives_q;
  assign CC_ROUNDCTRL_level_OutBUS    = level_q;
  assign CC_ROUNDCTRL_gameOver_Out    = over_q;
  assign CC_ROUNDCTRL_gameWon_Out     = won_q;

endmodule

// File: tb/tb_cc_frogger_round_controller.sv
// Vector-table bench for the Frogger round controller: each vector drives one
// clock of inputs and queues the outputs expected after that edge.
module tb_cc_frogger_round_controller;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;
  localparam logic [2:0] S_PLAY = 3'b010;
  localparam logic [2:0] S_HIT  = 3'b011;
  localparam logic [2:0] S_WIN  = 3'b100;
  localparam logic [2:0] S_OVER = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmp = 2'b00;
  logic       load_o, shift_o, over_o, won_o;
  logic [2:0] state_o;
  logic [1:0] lives_o;
  logic [2:0] level_o;

  always #5 clk = ~clk;

  cc_frogger_round_controller dut (
    .CC_ROUNDCTRL_CLOCK_50        (clk),
    .CC_ROUNDCTRL_RESET_InHigh    (rst),
    .CC_ROUNDCTRL_tick_In         (tick),
    .CC_ROUNDCTRL_start_In        (start),
    .CC_ROUNDCTRL_compare_InBUS   (cmp),
    .CC_ROUNDCTRL_load_Out        (load_o),
    .CC_ROUNDCTRL_shiftEnable_Out (shift_o),
    .CC_ROUNDCTRL_state_OutBUS    (state_o),
    .CC_ROUNDCTRL_lives_OutBUS    (lives_o),
    .CC_ROUNDCTRL_level_OutBUS    (level_o),
    .CC_ROUNDCTRL_gameOver_Out    (over_o),
    .CC_ROUNDCTRL_gameWon_Out     (won_o)
  );

  typedef struct {
    logic       rst;
    logic       tick;
    logic       start;
    logic [1:0] cmp;
    logic [2:0] st;
    logic [1:0] lv;
    logic [2:0] lvl;
    logic       won;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic add(input logic r, input logic t, input logic s, input logic [1:0] c,
                     input logic [2:0] st, input logic [1:0] lv, input logic [2:0] lvl,
                     input logic wn);
    vec_t v;
    v.rst = r; v.tick = t; v.start = s; v.cmp = c;
    v.st = st; v.lv = lv; v.lvl = lvl; v.won = wn;
    vecs.push_back(v);
  endtask

  // Expected outputs: {state, lives, level, load, shiftEnable, gameOver, gameWon}.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      logic [11:0] e;
      logic [11:0] got;
      rst   = vecs[i].rst;
      tick  = vecs[i].tick;
      start = vecs[i].start;
      cmp   = vecs[i].cmp;
      exp_q.push_back({vecs[i].st, vecs[i].lv, vecs[i].lvl,
                       vecs[i].st == S_LOAD, vecs[i].st == S_PLAY,
                       vecs[i].st == S_OVER, vecs[i].won});
      @(posedge clk);
      #1;
      got = {state_o, lives_o, level_o, load_o, shift_o, over_o, won_o};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s[%0d]: got st=%0d lives=%0d lvl=%0d ld=%b sh=%b ov=%b won=%b, expected st=%0d lives=%0d lvl=%0d ld=%b sh=%b ov=%b won=%b",
                 tag, i, got[11:9], got[8:7], got[6:4], got[3], got[2], got[1], got[0],
                 e[11:9], e[8:7], e[6:4], e[3], e[2], e[1], e[0]);
      end
    end
    vecs.delete();
  endtask

  initial begin
    // Basic flow, ignored inputs, one miss, two wins, then reset mid-PLAY.
    add(1'b1, 1'b0, 1'b0, 2'b00, S_IDLE, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_IDLE, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b01, S_IDLE, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 2'b00, S_LOAD, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b11, S_PLAY, 2'd3, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_PLAY, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b10, S_PLAY, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b01, S_PLAY, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 2'b00, S_PLAY, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b01, S_HIT,  2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 2'b00, S_HIT,  2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_HIT,  2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b11, S_HIT,  2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_HIT,  2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_HIT,  2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_LOAD, 2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b11, S_PLAY, 2'd2, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b11, S_WIN,  2'd2, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_WIN, 2'd2, 3'd1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_LOAD, 2'd2, 3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd2, 3'd1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b11, S_WIN,  2'd2, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_WIN, 2'd2, 3'd2, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_LOAD, 2'd2, 3'd2, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd2, 3'd2, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b01, S_HIT,  2'd1, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_HIT, 2'd1, 3'd2, 1'b0);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_LOAD, 2'd1, 3'd2, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd1, 3'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 2'b00, S_IDLE, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_IDLE, 2'd3, 3'd0, 1'b0);
    run_vecs("basic");

    // Three misses run lives down to zero and end in OVER; start restarts.
    add(1'b0, 1'b0, 1'b1, 2'b00, S_LOAD, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd3, 3'd0, 1'b0);
    for (int lv = 2; lv >= 0; lv--) begin
      add(1'b0, 1'b1, 1'b0, 2'b01, S_HIT, 2'(lv), 3'd0, 1'b0);
      for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_HIT, 2'(lv), 3'd0, 1'b0);
      if (lv > 0) begin
        add(1'b0, 1'b1, 1'b0, 2'b00, S_LOAD, 2'(lv), 3'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'(lv), 3'd0, 1'b0);
      end else begin
        add(1'b0, 1'b1, 1'b0, 2'b00, S_OVER, 2'd0, 3'd0, 1'b0);
      end
    end
    add(1'b0, 1'b1, 1'b0, 2'b01, S_OVER, 2'd0, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 2'b00, S_LOAD, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd3, 3'd0, 1'b0);
    run_vecs("lives");

    // Seven wins climb to LEVEL_MAX; the eighth sets gameWon and ends in OVER.
    for (int l = 1; l <= 7; l++) begin
      add(1'b0, 1'b1, 1'b0, 2'b11, S_WIN, 2'd3, 3'(l), 1'b0);
      for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_WIN, 2'd3, 3'(l), 1'b0);
      add(1'b0, 1'b1, 1'b0, 2'b00, S_LOAD, 2'd3, 3'(l), 1'b0);
      add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd3, 3'(l), 1'b0);
    end
    add(1'b0, 1'b1, 1'b0, 2'b11, S_WIN, 2'd3, 3'd7, 1'b1);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_WIN, 2'd3, 3'd7, 1'b1);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 2'b00, S_WIN, 2'd3, 3'd7, 1'b1);
    add(1'b0, 1'b1, 1'b0, 2'b00, S_OVER, 2'd3, 3'd7, 1'b1);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_OVER, 2'd3, 3'd7, 1'b1);
    add(1'b0, 1'b0, 1'b1, 2'b00, S_LOAD, 2'd3, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2'b00, S_PLAY, 2'd3, 3'd0, 1'b0);
    run_vecs("levels");

    tick  = 1'b0;
    start = 1'b0;
    cmp   = 2'b00;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
